// File: rtl/oam_dma.sv
// oam_dma: OAM DMA engine behind the CPU $4014 register.
// A page write halts the CPU and copies CPU page $XX00-$XXFF into PPU OAMDATA.
// Each byte takes one get/put CPU-cycle pair, aligned to the free-running
// get/put parity, so a transfer costs 513 or 514 halted CPU cycles.
module oam_dma #(
   parameter logic [2:0] P_oamdata_reg = 3'd4
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_cpu_tick,
   input  logic        I_cpu_read,
   input  logic        I_reg_wren,
   input  logic [7:0]  I_reg_data,
   output logic        O_cpu_halt,
   output logic        O_busy,
   output logic [15:0] O_bus_addr,
   output logic        O_bus_rden,
   input  logic [7:0]  I_bus_data,
   output logic [2:0]  O_ppu_addr,
   output logic        O_ppu_wren,
   output logic [7:0]  O_ppu_data
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_HALT  = 3'd2,
      ST_ALIGN = 3'd3,
      ST_GET   = 3'd4,
      ST_PUT   = 3'd5
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        parity_r;
   logic [7:0]  page_r;
   logic [7:0]  page_s;
   logic [7:0]  count_r;
   logic [7:0]  count_s;

   logic        cpu_halt_r;
   logic        cpu_halt_s;
   logic        busy_r;
   logic        busy_s;
   logic [15:0] bus_addr_r;
   logic [15:0] bus_addr_s;
   logic        bus_rden_r;
   logic        bus_rden_s;
   logic        ppu_wren_r;
   logic        ppu_wren_s;
   logic [7:0]  ppu_data_r;
   logic [7:0]  ppu_data_s;
   logic [2:0]  ppu_addr_r;

   // Source address: the page never receives a carry from the byte counter.
   function automatic logic [15:0] dma_addr(input logic [7:0] page, input logic [7:0] count);
      return {page, count};
   endfunction

   // Get/put parity: toggles on every CPU cycle boundary, DMA active or not.
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         parity_r <= 1'b0;
      end else if (I_cpu_tick) begin
         parity_r <= ~parity_r;
      end else begin
         parity_r <= parity_r;
      end
   end

   // State register.
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; the machine only moves on CPU cycle boundaries.
   always_comb begin
      state_s = state_r;
      if (I_cpu_tick) begin
         case (state_r)
            ST_IDLE: begin
               if (I_reg_wren) state_s = ST_ARMED;
               else            state_s = ST_IDLE;
            end
            ST_ARMED: begin
               // The CPU can only be halted on one of its read cycles.
               if (I_cpu_read) state_s = ST_HALT;
               else            state_s = ST_ARMED;
            end
            ST_HALT: begin
               // Parity 0 means the halt cycle was a get, so the next is a put.
               if (!parity_r) state_s = ST_ALIGN;
               else           state_s = ST_GET;
            end
            ST_ALIGN: state_s = ST_GET;
            ST_GET:   state_s = ST_PUT;
            ST_PUT: begin
               if (count_r == 8'hFF) state_s = ST_IDLE;
               else                  state_s = ST_GET;
            end
            default:  state_s = ST_IDLE;
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Page latch and byte counter next values.
   always_comb begin
      page_s  = page_r;
      count_s = count_r;
      if (I_cpu_tick && (state_r == ST_IDLE) && I_reg_wren) begin
         page_s  = I_reg_data;
         count_s = 8'h00;
      end else if (I_cpu_tick && (state_r == ST_PUT)) begin
         count_s = count_r + 8'd1;
      end else begin
         page_s  = page_r;
         count_s = count_r;
      end
   end

   // Page latch and byte counter registers.
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         page_r  <= 8'h00;
         count_r <= 8'h00;
      end else begin
         page_r  <= page_s;
         count_r <= count_s;
      end
   end

   // Output next values, derived from the state being entered on this clock.
   always_comb begin
      cpu_halt_s = (state_s != ST_IDLE);
      busy_s     = (state_s != ST_IDLE);
      bus_rden_s = (state_s == ST_GET);
      if (state_s == ST_GET) begin
         bus_addr_s = dma_addr(page_s, count_s);
      end else begin
         bus_addr_s = bus_addr_r;
      end
      ppu_wren_s = I_cpu_tick && (state_r == ST_PUT);
      if (I_cpu_tick && (state_r == ST_GET)) begin
         ppu_data_s = I_bus_data;
      end else begin
         ppu_data_s = ppu_data_r;
      end
   end

   // Output registers.
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         cpu_halt_r <= 1'b0;
         busy_r     <= 1'b0;
         bus_addr_r <= 16'h0000;
         bus_rden_r <= 1'b0;
         ppu_wren_r <= 1'b0;
         ppu_data_r <= 8'h00;
         ppu_addr_r <= P_oamdata_reg;
      end else begin
         cpu_halt_r <= cpu_halt_s;
         busy_r     <= busy_s;
         bus_addr_r <= bus_addr_s;
         bus_rden_r <= bus_rden_s;
         ppu_wren_r <= ppu_wren_s;
         ppu_data_r <= ppu_data_s;
         ppu_addr_r <= P_oamdata_reg;
      end
   end

   assign O_cpu_halt = cpu_halt_r;
   assign O_busy     = busy_r;
   assign O_bus_addr = bus_addr_r;
   assign O_bus_rden = bus_rden_r;
   assign O_ppu_wren = ppu_wren_r;
   assign O_ppu_data = ppu_data_r;
   assign O_ppu_addr = ppu_addr_r;

endmodule
